// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the FIFO family.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width; a one-bit pointer still needs at least one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width; must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_dpram.sv
// WIDTH x DEPTH storage with one synchronous write port and one read port.
// READ_REG=1 gives a registered read with enable (reset to zero);
// READ_REG=0 gives an asynchronous read of the addressed word.
module sync_dpram #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int READ_REG = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    generate
        if (READ_REG != 0) begin : g_reg_read
            // Registered read: load on enable, hold otherwise.
            always_ff @(posedge clk) begin
                if (!rstn)      rd_data <= '0;
                else if (rd_en) rd_data <= mem[rd_addr];
            end
        end else begin : g_async_read
            logic unused_ctrl;
            assign unused_ctrl = rstn ^ rd_en;
            assign rd_data     = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read, programmable almost thresholds, occupancy count and sticky errors.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_STD
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   data_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

    generate
        if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
            AE_THRESH < 0 || AE_THRESH > DEPTH - 1 ||
            (FWFT != FIFO_STD && FWFT != FIFO_FWFT)) begin : g_bad_params
            $fatal(1, "sync_fifo_flex: illegal DEPTH/threshold/FWFT parameters");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_acc;
    logic             rd_acc;

    // Flags decode straight from the registered count, so accept decisions
    // never depend on the other side's request in the same cycle.
    assign fifo_full    = (count == DEPTH_C);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign data_count   = count;

    assign wr_acc = wr_en & ~fifo_full;
    assign rd_acc = rd_en & ~fifo_empty;

    // Pointer and occupancy update with explicit wrap at DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & fifo_full) overflow <= 1'b1;
            else if (err_clr)      overflow <= 1'b0;
            if (rd_en & fifo_empty) underflow <= 1'b1;
            else if (err_clr)       underflow <= 1'b0;
        end
    end

    sync_dpram #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_W   (PTR_W),
        .READ_REG ((FWFT == FIFO_FWFT) ? 0 : 1)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_acc & rstn),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc & rstn),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
